// File: rtl/gray_frame_ctrl.sv
// Frame controller around an external RGB555->gray core: counts pixels per frame,
// tags line/frame ends and buffers core results in a 2-entry output FIFO.
module gray_frame_ctrl #(
  parameter int MAX_PIXEL_BITS  = 15,
  parameter int PIXEL_WIDTH_OUT = 8,
  parameter int DIM_BITS        = 10
) (
  input  logic                       clk_i,
  input  logic                       nreset_i,
  input  logic                       frame_start_i,
  input  logic                       abort_i,
  input  logic [DIM_BITS-1:0]        cfg_width_i,
  input  logic [DIM_BITS-1:0]        cfg_height_i,
  input  logic                       in_valid_i,
  input  logic [MAX_PIXEL_BITS-1:0]  in_px_i,
  output logic                       in_ready_o,
  output logic                       core_start_o,
  output logic [MAX_PIXEL_BITS-1:0]  core_px_o,
  input  logic [PIXEL_WIDTH_OUT-1:0] core_gray_i,
  output logic                       out_valid_o,
  output logic [PIXEL_WIDTH_OUT-1:0] out_px_o,
  output logic                       out_eol_o,
  output logic                       out_eof_o,
  input  logic                       out_ready_i,
  output logic                       busy_o,
  output logic                       frame_done_o
);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  typedef struct packed {
    logic [PIXEL_WIDTH_OUT-1:0] px;
    logic                       eol;
    logic                       eof;
  } entry_t;

  localparam logic [DIM_BITS-1:0] DIM_ONE = DIM_BITS'(1);

  state_t              state, state_nxt;
  logic [DIM_BITS-1:0] width_q, height_q, x_q, y_q;
  logic                inflight_q, tag_eol_q, tag_eof_q;
  entry_t              fifo_mem [2];
  entry_t              head;
  logic                wr_ptr, rd_ptr;
  logic [1:0]          count, occ;
  logic                accept, push, pop, px_eol, px_eof, start_ok;

  // Occupancy includes the pixel still inside the core so the FIFO can never overflow.
  assign occ          = count + {1'b0, inflight_q};
  assign in_ready_o   = (state == STREAM) && (occ < 2'd2) && !abort_i;
  assign accept       = in_valid_i & in_ready_o;
  assign core_start_o = accept;
  assign core_px_o    = in_px_i;

  assign push        = inflight_q && !abort_i;
  assign out_valid_o = (count != 2'd0);
  assign pop         = out_valid_o & out_ready_i;
  assign head        = out_valid_o ? fifo_mem[rd_ptr] : '0;
  assign out_px_o    = head.px;
  assign out_eol_o   = head.eol;
  assign out_eof_o   = head.eof;
  assign busy_o      = (state != IDLE);

  assign px_eol   = (x_q == width_q - DIM_ONE);
  assign px_eof   = px_eol && (y_q == height_q - DIM_ONE);
  assign start_ok = frame_start_i && (cfg_width_i != '0) && (cfg_height_i != '0);

  always_comb begin
    state_nxt    = state;
    frame_done_o = 1'b0;
    case (state)
      IDLE:   if (start_ok) state_nxt = STREAM;
      STREAM: if (accept && px_eof) state_nxt = DRAIN;
      DRAIN: begin
        if (!inflight_q && (count == 2'd0) && !pop) begin
          state_nxt    = IDLE;
          frame_done_o = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (abort_i) begin
      state_nxt    = IDLE;
      frame_done_o = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state      <= IDLE;
      width_q    <= '0;
      height_q   <= '0;
      x_q        <= '0;
      y_q        <= '0;
      inflight_q <= 1'b0;
      tag_eol_q  <= 1'b0;
      tag_eof_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (abort_i) begin
        x_q        <= '0;
        y_q        <= '0;
        inflight_q <= 1'b0;
      end else begin
        inflight_q <= accept;
        if (state == IDLE && start_ok) begin
          width_q  <= cfg_width_i;
          height_q <= cfg_height_i;
          x_q      <= '0;
          y_q      <= '0;
        end else if (accept) begin
          tag_eol_q <= px_eol;
          tag_eof_q <= px_eof;
          if (px_eol) begin
            x_q <= '0;
            y_q <= y_q + DIM_ONE;
          end else begin
            x_q <= x_q + DIM_ONE;
          end
        end
      end
    end
  end

  // The core result is valid exactly one cycle after its start, so it is captured here unconditionally on push.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      for (int i = 0; i < 2; i++) fifo_mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (abort_i) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= '{px: core_gray_i, eol: tag_eol_q, eof: tag_eof_q};
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_gray_frame_ctrl.sv
// Scoreboard bench for gray_frame_ctrl with a behavioural one-cycle gray core.
module tb_gray_frame_ctrl;

  typedef struct {
    logic [7:0] px;
    logic       eol;
    logic       eof;
  } exp_t;

  logic        clk = 1'b0;
  logic        nreset, frame_start, abort_s, in_valid, in_ready, core_start;
  logic [9:0]  cfg_w, cfg_h;
  logic [14:0] in_px, core_px;
  logic [7:0]  core_gray, out_px;
  logic        out_valid, out_eol, out_eof, out_ready, busy, frame_done;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_chk = 0, n_pass = 0;
  int   cyc = 0, acc_cnt = 0, done_cnt = 0, done_cyc = 0, eof_pop_cyc = 0;
  int   d0, a0;

  gray_frame_ctrl #(.MAX_PIXEL_BITS(15), .PIXEL_WIDTH_OUT(8), .DIM_BITS(10)) dut (
    .clk_i(clk), .nreset_i(nreset), .frame_start_i(frame_start), .abort_i(abort_s),
    .cfg_width_i(cfg_w), .cfg_height_i(cfg_h), .in_valid_i(in_valid), .in_px_i(in_px),
    .in_ready_o(in_ready), .core_start_o(core_start), .core_px_o(core_px),
    .core_gray_i(core_gray), .out_valid_o(out_valid), .out_px_o(out_px),
    .out_eol_o(out_eol), .out_eof_o(out_eof), .out_ready_i(out_ready),
    .busy_o(busy), .frame_done_o(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gray_fn(input logic [14:0] p);
    logic [15:0] s;
    s = 16'd36 * {11'd0, p[14:10]} + 16'd72 * {11'd0, p[9:5]} + 16'd11 * {11'd0, p[4:0]};
    return s[11:4];
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (core_start) core_gray <= gray_fn(core_px);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (core_start) acc_cnt++;
    if (frame_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) check("unexpected_out", 32'(out_px), 32'hFFFF);
      else begin
        mon_e = exp_q.pop_front();
        check("out_px", 32'(out_px), 32'(mon_e.px));
        check("out_tags", 32'({out_eol, out_eof}), 32'({mon_e.eol, mon_e.eof}));
        if (out_eof) eof_pop_cyc = cyc;
      end
    end
  end

  task automatic start_frame(input int w, input int h);
    cfg_w = 10'(w);
    cfg_h = 10'(h);
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  // Holds the pixel until accepted; the expected result is queued at the accept.
  task automatic drive_px(input logic [14:0] px, input logic [7:0] g, input logic eol, input logic eof);
    int t = 0;
    in_valid = 1'b1;
    in_px    = px;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("accept_timeout", 32'd0, 32'd1);
    else exp_q.push_back('{px: g, eol: eol, eof: eof});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int base);
    int t = 0;
    while (done_cnt == base && t < 100) begin
      @(posedge clk);
      t++;
    end
    #1;
    check({name, "_done_seen"}, 32'(done_cnt - base), 32'd1);
    check({name, "_done_lat"}, 32'(done_cyc - eof_pop_cyc), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check({name, "_done_once"}, 32'(done_cnt - base), 32'd1);
    check({name, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    nreset = 1'b0; frame_start = 1'b0; abort_s = 1'b0; cfg_w = '0; cfg_h = '0;
    in_valid = 1'b0; in_px = '0; out_ready = 1'b1; core_gray = '0;
    repeat (2) @(negedge clk);
    check("reset_outs", 32'({out_valid, busy, in_ready, out_eol, out_eof, frame_done, core_start, out_px}), 32'd0);
    nreset = 1'b1;
    @(posedge clk); #1;

    // Scenario 1: 2x2 primary colours
    d0 = done_cnt;
    start_frame(2, 2);
    check("s1_busy", 32'(busy), 32'd1);
    drive_px(15'h7FFF, 8'd230, 1'b0, 1'b0);
    drive_px(15'h0000, 8'd0,   1'b1, 1'b0);
    drive_px(15'h7C00, 8'd69,  1'b0, 1'b0);
    drive_px(15'h03E0, 8'd139, 1'b1, 1'b1);
    wait_done("s1", d0);

    // Scenario 2: 4x1 with backpressure
    d0 = done_cnt;
    out_ready = 1'b0;
    start_frame(4, 1);
    drive_px(15'h001F, 8'd21, 1'b0, 1'b0);
    drive_px(15'h0421, 8'd7,  1'b0, 1'b0);
    in_valid = 1'b1;
    in_px    = 15'h7FE0;
    repeat (3) begin
      @(negedge clk);
      check("s2_ready_low", 32'(in_ready), 32'd0);
    end
    check("s2_out_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    drive_px(15'h7FE0, 8'd209, 1'b0, 1'b0);
    drive_px(15'h2108, 8'd59,  1'b1, 1'b1);
    wait_done("s2", d0);

    // Scenario 3: abort after 3 of 4 pixels
    d0 = done_cnt;
    start_frame(4, 1);
    drive_px(15'h4210, 8'd119, 1'b0, 1'b0);
    drive_px(15'h7C1F, 8'd91,  1'b0, 1'b0);
    drive_px(15'h0001, 8'd0,   1'b0, 1'b0);
    abort_s  = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    check("s3_abort_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    abort_s  = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("s3_valid_busy", 32'({out_valid, busy}), 32'd0);
    repeat (4) @(negedge clk);
    check("s3_no_done", 32'(done_cnt - d0), 32'd0);
    @(posedge clk); #1;

    // Scenario 4: zero dimensions keep the FSM idle
    cfg_w = 10'd0; cfg_h = 10'd2; frame_start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("s4_zero_w", 32'(busy), 32'd0);
    cfg_w = 10'd2; cfg_h = 10'd0;
    @(negedge clk);
    @(negedge clk);
    check("s4_zero_h", 32'(busy), 32'd0);
    @(posedge clk); #1;
    frame_start = 1'b0;

    // Scenario 5: reset in DRAIN, then a normal frame
    out_ready = 1'b0;
    start_frame(2, 1);
    drive_px(15'h7C00, 8'd69,  1'b0, 1'b0);
    drive_px(15'h03E0, 8'd139, 1'b1, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("s5_drain_busy", 32'({busy, out_valid}), 32'd3);
    #2;
    nreset = 1'b0;
    #1;
    check("s5_reset_outs", 32'({out_valid, busy, in_ready, out_eol, out_eof, frame_done, core_start, out_px}), 32'd0);
    exp_q.delete();
    @(negedge clk);
    nreset = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_px     = 15'h7FFF;
    repeat (2) begin
      @(negedge clk);
      check("s5_need_start", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    d0 = done_cnt;
    start_frame(2, 2);
    drive_px(15'h001F, 8'd21,  1'b0, 1'b0);
    drive_px(15'h7FE0, 8'd209, 1'b1, 1'b0);
    drive_px(15'h4210, 8'd119, 1'b0, 1'b0);
    drive_px(15'h0421, 8'd7,   1'b1, 1'b1);
    wait_done("s5", d0);

    // Scenario 6: 1x1 frame with input held valid
    d0 = done_cnt;
    a0 = acc_cnt;
    start_frame(1, 1);
    drive_px(15'h4210, 8'd119, 1'b1, 1'b1);
    in_valid = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("s6_one_accept", 32'(acc_cnt - a0), 32'd1);
    wait_done("s6", d0);

    begin
      int t = 0;
      while (exp_q.size() != 0 && t < 50) begin
        @(posedge clk);
        t++;
      end
    end
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/gray_frame_ctrl.md
GRAY_FRAME_CTRL -- requirements
Module: gray_frame_ctrl

Interface
REQ-001 Parameters (name, default, meaning): MAX_PIXEL_BITS, 15, RGB555 input width; PIXEL_WIDTH_OUT, 8, gray width; DIM_BITS, 10, frame width/height counter width.
REQ-002 Ports (name, direction, width, meaning), clock and reset first:
- clk_i  in  1  single clock, rising edge.
- nreset_i  in  1  asynchronous active-low reset.
- frame_start_i  in  1  begin frame, sampled in IDLE.
- abort_i  in  1  synchronous abort.
- cfg_width_i  in  DIM_BITS  pixels per line.
- cfg_height_i  in  DIM_BITS  lines per frame.
- in_valid_i  in  1  input pixel valid.
- in_px_i  in  MAX_PIXEL_BITS  RGB555 pixel.
- in_ready_o  out  1  controller accepts pixel.
- core_start_o  out  1  to gray core start_i.
- core_px_o  out  MAX_PIXEL_BITS  to gray core in_px_rgb_i.
- core_gray_i  in  PIXEL_WIDTH_OUT  from gray core out_px_gray_o.
- out_valid_o  out  1  gray pixel valid.
- out_px_o  out  PIXEL_WIDTH_OUT  gray pixel.
- out_eol_o  out  1  last pixel of line.
- out_eof_o  out  1  last pixel of frame.
- out_ready_i  in  1  downstream accepts.
- busy_o  out  1  state != IDLE.
- frame_done_o  out  1  one-cycle completion pulse.

Function
REQ-003 FSM states: IDLE, STREAM, DRAIN.
REQ-004 IDLE->STREAM when frame_start_i=1 and both cfg values nonzero; width/height latched at that edge; a zero dimension leaves the FSM in IDLE.
REQ-005 Accept = in_valid_i & in_ready_o; in_ready_o=1 only in STREAM when (FIFO occupancy + in-flight flag) < 2.
REQ-006 core_start_o = accept (combinational); core_px_o = in_px_i passed straight through.
REQ-007 In-flight flag registers accept; the cycle after an accept, core_gray_i is pushed into a 2-entry output FIFO with its eol/eof tags; core_gray_i is ignored when the flag is 0.
REQ-008 Latency from accept to out_valid_o with an empty FIFO: exactly 2 cycles (1 cycle core, 1 cycle FIFO write).
REQ-009 x/y counters advance on accept; x wraps to 0 at width-1 and y increments; the tag eol = (x==width-1), eof = eol & (y==height-1).
REQ-010 STREAM->DRAIN on the accept of the eof pixel; no further accepts in the frame.
REQ-011 DRAIN->IDLE when the in-flight flag is 0, the FIFO is empty, and no pop occurs that cycle; frame_done_o pulses for 1 cycle on that transition.
REQ-012 out_valid_o = FIFO non-empty; out_px_o/out_eol_o/out_eof_o = head entry; pop on out_valid_o & out_ready_i.
REQ-013 A push and pop in the same cycle leave occupancy unchanged; the FIFO never overflows, as guaranteed by REQ-005.
REQ-014 out_px_o stays stable while out_valid_o=1 and out_ready_i=0.
REQ-015 abort_i=1 in any state: next state IDLE, counters and FIFO cleared, in-flight flag cleared, in_ready_o=0 that cycle, no frame_done_o; abort_i has priority over frame_start_i.
REQ-016 frame_start_i outside IDLE is ignored.

Reset
REQ-017 nreset_i low: state IDLE; counters, FIFO, and in-flight flag cleared; in_ready_o, core_start_o, out_valid_o, out_eol_o, out_eof_o, busy_o, and frame_done_o = 0; out_px_o = 0.
REQ-018 Reset takes effect asynchronously mid-frame; the first frame after release requires a new frame_start_i.

Verification
REQ-019 Scenario 1: width=2, height=2, pixels 0x7FFF, 0x0000, 0x7C00, 0x03E0, out_ready_i=1 -> outputs 230, 0, 69, 139; eol on the 2nd and 4th outputs; eof on the 4th; frame_done_o 1 cycle after the last pop.
REQ-020 Scenario 2: width=4, height=1, out_ready_i=0 -> in_ready_o drops after 2 accepts; releasing out_ready_i yields all 4 outputs in order with none lost.
REQ-021 Scenario 3: abort_i after 3 of 4 pixels -> out_valid_o=0 and busy_o=0 next cycle, no frame_done_o.
REQ-022 Scenario 4: frame_start_i with cfg_width_i=0 -> busy_o stays 0.
REQ-023 Scenario 5: nreset_i asserted mid-DRAIN -> all outputs 0 immediately; a new frame then completes normally.
REQ-024 Scenario 6: single-pixel frame (1x1) with in_valid_i held high -> exactly one accept; output tagged eol=1 and eof=1.
